// File: rtl/bno085_report_if.sv
// Byte-stream input and published-sample output bundle of the BNO085 report parser.
// The slave side is the parser. The master side is whoever feeds it bytes and reads the samples.
interface bno085_report_if;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_first;
  logic               hold;
  logic               quat_valid;
  logic signed [15:0] quat_w;
  logic signed [15:0] quat_x;
  logic signed [15:0] quat_y;
  logic signed [15:0] quat_z;
  logic               gyro_valid;
  logic signed [15:0] gyro_x;
  logic signed [15:0] gyro_y;
  logic signed [15:0] gyro_z;
  logic               quat_upd;
  logic               gyro_upd;

  modport master (
    output rx_valid, rx_data, rx_first, hold,
    input  quat_valid, quat_w, quat_x, quat_y, quat_z,
    input  gyro_valid, gyro_x, gyro_y, gyro_z, quat_upd, gyro_upd
  );

  modport slave (
    input  rx_valid, rx_data, rx_first, hold,
    output quat_valid, quat_w, quat_x, quat_y, quat_z,
    output gyro_valid, gyro_x, gyro_y, gyro_z, quat_upd, gyro_upd
  );
endinterface

// File: rtl/bno085_report_parser.sv
// SHTP byte-stream parser that extracts BNO085 rotation-vector and calibrated-gyro reports.
// It holds the latest samples stable and defers publishing while hold is high.
module bno085_report_parser #(
  parameter logic [7:0] SENSOR_CHANNEL = 8'd3,
  parameter logic [7:0] QUAT_RID       = 8'h05,
  parameter logic [7:0] GYRO_RID       = 8'h02
) (
  input  logic            clk,
  input  logic            rst,
  bno085_report_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RID, S_TBASE, S_QBODY, S_GBODY, S_SKIP
  } state_t;

  state_t            state_q, state_d, body_exit;
  logic [14:0]       idx_q, idx_d, len_q, len_d;
  logic [15:0]       idx_inc;
  logic [7:0]        chan_q, chan_d;
  logic [3:0]        pos_q, pos_d, pos_m4;
  logic [1:0]        fsel;
  logic              q_commit, g_commit;
  // Field order: quat [0]=i [1]=j [2]=k [3]=real; gyro [0]=x [1]=y [2]=z
  logic [3:0][15:0]  qstg_q, qstg_d, qpend_q, qpend_d, qout_q, qout_d;
  logic [2:0][15:0]  gstg_q, gstg_d, gpend_q, gpend_d, gout_q, gout_d;
  logic              qpend_vld_q, qpend_vld_d, gpend_vld_q, gpend_vld_d;
  logic              quat_valid_q, quat_valid_d, gyro_valid_q, gyro_valid_d;
  logic              quat_upd_q, quat_upd_d, gyro_upd_q, gyro_upd_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    chan_d   = chan_q;
    pos_d    = pos_q;
    qstg_d   = qstg_q;
    gstg_d   = gstg_q;
    q_commit = 1'b0;
    g_commit = 1'b0;
    idx_inc  = {1'b0, idx_q} + 16'd1;
    pos_m4   = pos_q - 4'd4;
    fsel     = pos_m4[2:1];
    body_exit = (idx_inc < {1'b0, len_q}) ? S_RID : S_SKIP;

    if (bus.rx_valid) begin
      if (bus.rx_first) begin
        state_d = S_HDR;
        idx_d   = 15'd1;
        len_d   = {7'd0, bus.rx_data};
        chan_d  = 8'd0;
        pos_d   = 4'd0;
      end else if (state_q != S_IDLE) begin
        if (idx_q != '1) idx_d = idx_inc[14:0];
        unique case (state_q)
          S_HDR: begin
            if (idx_q == 15'd1) len_d[14:8] = bus.rx_data[6:0];
            else if (idx_q == 15'd2) chan_d = bus.rx_data;
            else if (chan_q != SENSOR_CHANNEL || len_q <= 15'd4) state_d = S_SKIP;
            else state_d = S_RID;
          end
          S_SKIP: ;
          default: begin
            // Anything at or past len is outside the transfer: drop it and any report in flight
            if (idx_q >= len_q) begin
              state_d = S_SKIP;
            end else begin
              pos_d = pos_q + 4'd1;
              case (state_q)
                S_RID: begin
                  pos_d = 4'd1;
                  if (bus.rx_data == 8'hFB || bus.rx_data == 8'hFA) state_d = S_TBASE;
                  else if (bus.rx_data == QUAT_RID) state_d = S_QBODY;
                  else if (bus.rx_data == GYRO_RID) state_d = S_GBODY;
                  else state_d = S_SKIP;
                end
                S_TBASE: if (pos_q == 4'd4) state_d = body_exit;
                S_QBODY: begin
                  if (pos_q >= 4'd4 && pos_q <= 4'd11) begin
                    if (pos_q[0]) qstg_d[fsel][15:8] = bus.rx_data;
                    else          qstg_d[fsel][7:0]  = bus.rx_data;
                  end
                  if (pos_q == 4'd13) begin
                    q_commit = 1'b1;
                    state_d  = body_exit;
                  end
                end
                S_GBODY: begin
                  if (pos_q >= 4'd4 && pos_q <= 4'd9) begin
                    if (pos_q[0]) gstg_d[fsel][15:8] = bus.rx_data;
                    else          gstg_d[fsel][7:0]  = bus.rx_data;
                  end
                  if (pos_q == 4'd9) begin
                    g_commit = 1'b1;
                    state_d  = body_exit;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  // Publish: a fresh commit wins over older pending data when hold is low
  always_comb begin
    qpend_d      = qpend_q;
    qpend_vld_d  = qpend_vld_q;
    qout_d       = qout_q;
    quat_valid_d = quat_valid_q;
    quat_upd_d   = 1'b0;
    gpend_d      = gpend_q;
    gpend_vld_d  = gpend_vld_q;
    gout_d       = gout_q;
    gyro_valid_d = gyro_valid_q;
    gyro_upd_d   = 1'b0;

    if (!bus.hold) begin
      if (q_commit || qpend_vld_q) begin
        qout_d       = q_commit ? qstg_d : qpend_q;
        quat_upd_d   = 1'b1;
        quat_valid_d = 1'b1;
        qpend_vld_d  = 1'b0;
      end
      if (g_commit || gpend_vld_q) begin
        gout_d       = g_commit ? gstg_d : gpend_q;
        gyro_upd_d   = 1'b1;
        gyro_valid_d = 1'b1;
        gpend_vld_d  = 1'b0;
      end
    end else begin
      if (q_commit) begin
        qpend_d     = qstg_d;
        qpend_vld_d = 1'b1;
      end
      if (g_commit) begin
        gpend_d     = gstg_d;
        gpend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      chan_q       <= '0;
      pos_q        <= '0;
      qstg_q       <= '0;
      gstg_q       <= '0;
      qpend_q      <= '0;
      gpend_q      <= '0;
      qpend_vld_q  <= 1'b0;
      gpend_vld_q  <= 1'b0;
      qout_q       <= '0;
      gout_q       <= '0;
      quat_valid_q <= 1'b0;
      gyro_valid_q <= 1'b0;
      quat_upd_q   <= 1'b0;
      gyro_upd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      chan_q       <= chan_d;
      pos_q        <= pos_d;
      qstg_q       <= qstg_d;
      gstg_q       <= gstg_d;
      qpend_q      <= qpend_d;
      gpend_q      <= gpend_d;
      qpend_vld_q  <= qpend_vld_d;
      gpend_vld_q  <= gpend_vld_d;
      qout_q       <= qout_d;
      gout_q       <= gout_d;
      quat_valid_q <= quat_valid_d;
      gyro_valid_q <= gyro_valid_d;
      quat_upd_q   <= quat_upd_d;
      gyro_upd_q   <= gyro_upd_d;
    end
  end

  assign bus.quat_x     = $signed(qout_q[0]);
  assign bus.quat_y     = $signed(qout_q[1]);
  assign bus.quat_z     = $signed(qout_q[2]);
  assign bus.quat_w     = $signed(qout_q[3]);
  assign bus.gyro_x     = $signed(gout_q[0]);
  assign bus.gyro_y     = $signed(gout_q[1]);
  assign bus.gyro_z     = $signed(gout_q[2]);
  assign bus.quat_valid = quat_valid_q;
  assign bus.gyro_valid = gyro_valid_q;
  assign bus.quat_upd   = quat_upd_q;
  assign bus.gyro_upd   = gyro_upd_q;
endmodule
